// File: rtl/tlb_unit_pkg.sv
// Shared TLB definitions: sizing, CP0 entryhi/entrylo field positions and the
// TLB_rdata layout, so CP0 and the TLB decode entries identically.
package tlb_unit_pkg;

  localparam int unsigned TLBNUM  = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned VPN2_W  = 19;
  localparam int unsigned ASID_W  = 8;
  localparam int unsigned PFN_W   = 20;
  localparam int unsigned C_W     = 3;
  localparam int unsigned RDATA_W = 78;

  // entryhi / entrylo field positions
  localparam int unsigned EH_VPN2_HI = 31;
  localparam int unsigned EH_VPN2_LO = 13;
  localparam int unsigned EH_ASID_HI = 7;
  localparam int unsigned EH_ASID_LO = 0;
  localparam int unsigned EL_PFN_HI  = 25;
  localparam int unsigned EL_PFN_LO  = 6;
  localparam int unsigned EL_C_HI    = 5;
  localparam int unsigned EL_C_LO    = 3;
  localparam int unsigned EL_D       = 2;
  localparam int unsigned EL_V       = 1;
  localparam int unsigned EL_G       = 0;

  // TLB_rdata bit positions
  localparam int unsigned RD_VPN2_HI = 77;
  localparam int unsigned RD_VPN2_LO = 59;
  localparam int unsigned RD_ASID_HI = 58;
  localparam int unsigned RD_ASID_LO = 51;
  localparam int unsigned RD_G       = 50;
  localparam int unsigned RD_PFN0_HI = 49;
  localparam int unsigned RD_PFN0_LO = 30;
  localparam int unsigned RD_C0_HI   = 29;
  localparam int unsigned RD_C0_LO   = 27;
  localparam int unsigned RD_D0      = 26;
  localparam int unsigned RD_V0      = 25;
  localparam int unsigned RD_PFN1_HI = 24;
  localparam int unsigned RD_PFN1_LO = 5;
  localparam int unsigned RD_C1_HI   = 4;
  localparam int unsigned RD_C1_LO   = 2;
  localparam int unsigned RD_D1      = 1;
  localparam int unsigned RD_V1      = 0;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    page_t            page;
  } lookup_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational associative match over all entries; lowest matching index wins.
module tlb_match
  import tlb_unit_pkg::*;
#(
  parameter int unsigned N = TLBNUM
) (
  input  logic [N-1:0][VPN2_W-1:0] vpn2,
  input  logic [N-1:0][ASID_W-1:0] asid,
  input  logic [N-1:0]             g,
  input  logic [VPN2_W-1:0]        q_vpn2,
  input  logic [ASID_W-1:0]        q_asid,
  output logic                     hit,
  output logic [IDX_W-1:0]         index
);

  // Scan high to low so the last assignment is the lowest matching entry.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vpn2[i] == q_vpn2 && (g[i] || asid[i] == q_asid)) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// MIPS-style joint TLB: two pipelined lookup ports, TLBWI/TLBWR write,
// combinational TLBR read and TLBP probe, free-running random index.
module tlb_unit #(
  parameter int unsigned TLBNUM = tlb_unit_pkg::TLBNUM
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              s0_req,
  input  logic [31:0]                       s0_vaddr,
  input  logic [7:0]                        s0_asid,
  output logic                              s0_found,
  output logic [3:0]                        s0_index,
  output logic [19:0]                       s0_pfn,
  output logic [2:0]                        s0_c,
  output logic                              s0_d,
  output logic                              s0_v,
  input  logic                              s1_req,
  input  logic [31:0]                       s1_vaddr,
  input  logic [7:0]                        s1_asid,
  output logic                              s1_found,
  output logic [3:0]                        s1_index,
  output logic [19:0]                       s1_pfn,
  output logic [2:0]                        s1_c,
  output logic                              s1_d,
  output logic                              s1_v,
  input  logic                              is_TLBWI,
  input  logic                              is_TLBWR,
  input  logic [31:0]                       cp0_index,
  input  logic [31:0]                       cp0_entryhi,
  input  logic [31:0]                       cp0_entrylo0,
  input  logic [31:0]                       cp0_entrylo1,
  input  logic                              is_TLBR,
  output logic [tlb_unit_pkg::RDATA_W-1:0]  TLB_rdata,
  input  logic                              is_TLBP,
  output logic                              index_write_p,
  output logic [3:0]                        index_write_index,
  output logic [3:0]                        tlb_random
);
  import tlb_unit_pkg::*;

  logic [TLBNUM-1:0][VPN2_W-1:0] vpn2;
  logic [TLBNUM-1:0][ASID_W-1:0] asid;
  logic [TLBNUM-1:0]             g;
  logic [TLBNUM-1:0]             v0;
  logic [TLBNUM-1:0]             v1;
  logic [PFN_W-1:0]              pfn0 [TLBNUM];
  logic [PFN_W-1:0]              pfn1 [TLBNUM];
  logic [C_W-1:0]                c0   [TLBNUM];
  logic [C_W-1:0]                c1   [TLBNUM];
  logic                          d0   [TLBNUM];
  logic                          d1   [TLBNUM];

  logic             we;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic             s0_hit, s1_hit, p_hit;
  logic [IDX_W-1:0] s0_hidx, s1_hidx, p_hidx;
  lookup_t          s0_q, s1_q;

  // TLBR/TLBP are pure combinational reads; their strobes only matter to CP0.
  logic unused_ok;
  assign unused_ok = is_TLBR ^ is_TLBP ^ (^cp0_index[31:IDX_W]);

  assign we   = is_TLBWI | is_TLBWR;
  assign widx = is_TLBWI ? cp0_index[IDX_W-1:0] : tlb_random;
  assign ridx = cp0_index[IDX_W-1:0];

  // Tag/payload storage needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      vpn2[widx] <= cp0_entryhi[EH_VPN2_HI:EH_VPN2_LO];
      asid[widx] <= cp0_entryhi[EH_ASID_HI:EH_ASID_LO];
      g[widx]    <= cp0_entrylo0[EL_G] & cp0_entrylo1[EL_G];
      pfn0[widx] <= cp0_entrylo0[EL_PFN_HI:EL_PFN_LO];
      c0[widx]   <= cp0_entrylo0[EL_C_HI:EL_C_LO];
      d0[widx]   <= cp0_entrylo0[EL_D];
      pfn1[widx] <= cp0_entrylo1[EL_PFN_HI:EL_PFN_LO];
      c1[widx]   <= cp0_entrylo1[EL_C_HI:EL_C_LO];
      d1[widx]   <= cp0_entrylo1[EL_D];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= '0;
      v1 <= '0;
    end else if (we) begin
      v0[widx] <= cp0_entrylo0[EL_V];
      v1[widx] <= cp0_entrylo1[EL_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tlb_random <= IDX_W'(TLBNUM - 1);
    end else if (tlb_random == '0) begin
      tlb_random <= IDX_W'(TLBNUM - 1);
    end else begin
      tlb_random <= tlb_random - 1'b1;
    end
  end

  tlb_match #(.N(TLBNUM)) u_match_s0 (
    .vpn2(vpn2), .asid(asid), .g(g),
    .q_vpn2(s0_vaddr[EH_VPN2_HI:EH_VPN2_LO]), .q_asid(s0_asid),
    .hit(s0_hit), .index(s0_hidx)
  );

  tlb_match #(.N(TLBNUM)) u_match_s1 (
    .vpn2(vpn2), .asid(asid), .g(g),
    .q_vpn2(s1_vaddr[EH_VPN2_HI:EH_VPN2_LO]), .q_asid(s1_asid),
    .hit(s1_hit), .index(s1_hidx)
  );

  tlb_match #(.N(TLBNUM)) u_match_p (
    .vpn2(vpn2), .asid(asid), .g(g),
    .q_vpn2(cp0_entryhi[EH_VPN2_HI:EH_VPN2_LO]),
    .q_asid(cp0_entryhi[EH_ASID_HI:EH_ASID_LO]),
    .hit(p_hit), .index(p_hidx)
  );

  // Odd/even page select; a miss yields an all-zero result.
  function automatic lookup_t resolve(input logic hit, input logic [IDX_W-1:0] idx,
                                      input logic odd);
    lookup_t r;
    r = '0;
    if (hit) begin
      r.found = 1'b1;
      r.index = idx;
      r.page  = odd ? '{pfn: pfn1[idx], c: c1[idx], d: d1[idx], v: v1[idx]}
                    : '{pfn: pfn0[idx], c: c0[idx], d: d0[idx], v: v0[idx]};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      if (s0_req) s0_q <= resolve(s0_hit, s0_hidx, s0_vaddr[12]);
      if (s1_req) s1_q <= resolve(s1_hit, s1_hidx, s1_vaddr[12]);
    end
  end

  assign s0_found = s0_q.found;
  assign s0_index = s0_q.index;
  assign s0_pfn   = s0_q.page.pfn;
  assign s0_c     = s0_q.page.c;
  assign s0_d     = s0_q.page.d;
  assign s0_v     = s0_q.page.v;
  assign s1_found = s1_q.found;
  assign s1_index = s1_q.index;
  assign s1_pfn   = s1_q.page.pfn;
  assign s1_c     = s1_q.page.c;
  assign s1_d     = s1_q.page.d;
  assign s1_v     = s1_q.page.v;

  always_comb begin
    TLB_rdata                         = '0;
    TLB_rdata[RD_VPN2_HI:RD_VPN2_LO] = vpn2[ridx];
    TLB_rdata[RD_ASID_HI:RD_ASID_LO] = asid[ridx];
    TLB_rdata[RD_G]                   = g[ridx];
    TLB_rdata[RD_PFN0_HI:RD_PFN0_LO] = pfn0[ridx];
    TLB_rdata[RD_C0_HI:RD_C0_LO]     = c0[ridx];
    TLB_rdata[RD_D0]                  = d0[ridx];
    TLB_rdata[RD_V0]                  = v0[ridx];
    TLB_rdata[RD_PFN1_HI:RD_PFN1_LO] = pfn1[ridx];
    TLB_rdata[RD_C1_HI:RD_C1_LO]     = c1[ridx];
    TLB_rdata[RD_D1]                  = d1[ridx];
    TLB_rdata[RD_V1]                  = v1[ridx];
  end

  assign index_write_p     = ~p_hit;
  assign index_write_index = p_hit ? p_hidx : '0;

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: inputs change on the falling edge, registered
// outputs are checked on the falling edge after the capturing rising edge.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req, s1_req;
  logic [31:0] s0_vaddr, s1_vaddr;
  logic [7:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic        is_TLBWI, is_TLBWR, is_TLBR, is_TLBP;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [77:0] TLB_rdata;
  logic        index_write_p;
  logic [3:0]  index_write_index;
  logic [3:0]  tlb_random;

  int total = 0;
  int bad   = 0;

  tlb_unit #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vaddr(s1_vaddr), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .is_TLBWI(is_TLBWI), .is_TLBWR(is_TLBWR),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .is_TLBR(is_TLBR), .TLB_rdata(TLB_rdata),
    .is_TLBP(is_TLBP), .index_write_p(index_write_p),
    .index_write_index(index_write_index), .tlb_random(tlb_random)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    s0_req = 1'b0; s1_req = 1'b0;
    is_TLBWI = 1'b0; is_TLBWR = 1'b0; is_TLBR = 1'b0; is_TLBP = 1'b0;
  endtask

  task automatic write_wi(input logic [31:0] idx, input logic [31:0] hi,
                          input logic [31:0] lo0, input logic [31:0] lo1);
    is_TLBWI = 1'b1; cp0_index = idx; cp0_entryhi = hi;
    cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    s0_req = 1'b1; s0_vaddr = 32'h0000_2000; s0_asid = 8'h00;
    tick(); tick();
    total++; if (s0_found !== 1'b0) begin bad++; $display("FAIL rst_found got=%0h exp=0", s0_found); end
    total++; if (s0_pfn !== 20'h0) begin bad++; $display("FAIL rst_pfn got=%0h exp=0", s0_pfn); end
    total++; if (s1_index !== 4'h0) begin bad++; $display("FAIL rst_s1_index got=%0h exp=0", s1_index); end
    total++; if (tlb_random !== 4'hf) begin bad++; $display("FAIL rst_random got=%0h exp=f", tlb_random); end
    reset = 1'b0;
    tick();
    total++; if (s0_found !== 1'b0 || s0_v !== 1'b0 || s0_pfn !== 20'h0) begin
      bad++; $display("FAIL post_rst_lookup got=%0h/%0h/%0h exp=0/0/0", s0_found, s0_v, s0_pfn);
    end
    idle();
  endtask

  task automatic test_random();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (tlb_random !== 4'h5) begin bad++; $display("FAIL random_10 got=%0h exp=5", tlb_random); end
    is_TLBWR = 1'b1; cp0_entryhi = 32'h00A0_0011;
    cp0_entrylo0 = 32'h0000_3016; cp0_entrylo1 = 32'h0000_3056;
    tick();
    idle();
    total++; if (tlb_random !== 4'h4) begin bad++; $display("FAIL random_after_wr got=%0h exp=4", tlb_random); end
    cp0_index = 32'd5; #1;
    total++; if (TLB_rdata[77:59] !== 19'h00500 || TLB_rdata[49:30] !== 20'h000c0 || TLB_rdata[25] !== 1'b1) begin
      bad++; $display("FAIL wr_entry5 got=%0h/%0h/%0h exp=500/c0/1", TLB_rdata[77:59], TLB_rdata[49:30], TLB_rdata[25]);
    end
    for (int i = 0; i < 4; i++) tick();
    total++; if (tlb_random !== 4'h0) begin bad++; $display("FAIL random_zero got=%0h exp=0", tlb_random); end
    tick();
    total++; if (tlb_random !== 4'hf) begin bad++; $display("FAIL random_wrap got=%0h exp=f", tlb_random); end
  endtask

  task automatic test_lookup();
    write_wi(32'd3, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056);
    tick();
    idle();
    s1_req = 1'b1; s1_vaddr = 32'h0040_3000; s1_asid = 8'h05;
    s0_req = 1'b1; s0_vaddr = 32'h0040_2000; s0_asid = 8'h05;
    tick();
    total++; if (s1_found !== 1'b1 || s1_index !== 4'd3) begin
      bad++; $display("FAIL s1_hit got=%0h/%0h exp=1/3", s1_found, s1_index);
    end
    total++; if (s1_pfn !== 20'h00041 || s1_c !== 3'd2 || s1_d !== 1'b1 || s1_v !== 1'b1) begin
      bad++; $display("FAIL s1_odd_page got=%0h/%0h/%0h/%0h exp=41/2/1/1", s1_pfn, s1_c, s1_d, s1_v);
    end
    total++; if (s0_found !== 1'b1 || s0_pfn !== 20'h00040) begin
      bad++; $display("FAIL s0_even_page got=%0h/%0h exp=1/40", s0_found, s0_pfn);
    end
    s1_req = 1'b0; s1_vaddr = 32'h1234_5000; s0_req = 1'b0;
    tick();
    total++; if (s1_found !== 1'b1 || s1_pfn !== 20'h00041) begin
      bad++; $display("FAIL s1_hold got=%0h/%0h exp=1/41", s1_found, s1_pfn);
    end
  endtask

  task automatic test_asid_global();
    s0_req = 1'b1; s0_vaddr = 32'h0040_3000; s0_asid = 8'h06;
    tick();
    total++; if (s0_found !== 1'b0 || s0_index !== 4'd0 || s0_pfn !== 20'h0) begin
      bad++; $display("FAIL asid_miss got=%0h/%0h/%0h exp=0/0/0", s0_found, s0_index, s0_pfn);
    end
    s0_req = 1'b0;
    write_wi(32'd3, 32'h0040_2005, 32'h0000_1017, 32'h0000_1057);
    tick();
    idle();
    s0_req = 1'b1; s0_vaddr = 32'h0040_3000; s0_asid = 8'h06;
    tick();
    total++; if (s0_found !== 1'b1 || s0_index !== 4'd3 || s0_pfn !== 20'h00041) begin
      bad++; $display("FAIL global_hit got=%0h/%0h/%0h exp=1/3/41", s0_found, s0_index, s0_pfn);
    end
    idle();
  endtask

  task automatic test_probe_read();
    is_TLBP = 1'b1; cp0_entryhi = 32'h0040_2005; #1;
    total++; if (index_write_p !== 1'b0 || index_write_index !== 4'd3) begin
      bad++; $display("FAIL probe_hit got=%0h/%0h exp=0/3", index_write_p, index_write_index);
    end
    cp0_entryhi = 32'h1234_6005; #1;
    total++; if (index_write_p !== 1'b1 || index_write_index !== 4'd0) begin
      bad++; $display("FAIL probe_miss got=%0h/%0h exp=1/0", index_write_p, index_write_index);
    end
    is_TLBP = 1'b0; is_TLBR = 1'b1; cp0_index = 32'd3; #1;
    total++; if (TLB_rdata[77:59] !== 19'h00201 || TLB_rdata[58:51] !== 8'h05) begin
      bad++; $display("FAIL read_tag got=%0h/%0h exp=201/5", TLB_rdata[77:59], TLB_rdata[58:51]);
    end
    total++; if (TLB_rdata[49:30] !== 20'h00040 || TLB_rdata[24:5] !== 20'h00041 || TLB_rdata[50] !== 1'b1) begin
      bad++; $display("FAIL read_pfn got=%0h/%0h/%0h exp=40/41/1", TLB_rdata[49:30], TLB_rdata[24:5], TLB_rdata[50]);
    end
    total++; if (TLB_rdata[29:27] !== 3'd2 || TLB_rdata[26] !== 1'b1 || TLB_rdata[4:2] !== 3'd2 || TLB_rdata[0] !== 1'b1) begin
      bad++; $display("FAIL read_flags got=%0h/%0h/%0h/%0h exp=2/1/2/1", TLB_rdata[29:27], TLB_rdata[26], TLB_rdata[4:2], TLB_rdata[0]);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_multi_match();
    write_wi(32'd9, 32'h0040_2005, 32'h0000_2016, 32'h0000_2056);
    tick();
    idle();
    s0_req = 1'b1; s0_vaddr = 32'h0040_3000; s0_asid = 8'h05;
    tick();
    total++; if (s0_index !== 4'd3 || s0_pfn !== 20'h00041) begin
      bad++; $display("FAIL multi_lookup got=%0h/%0h exp=3/41", s0_index, s0_pfn);
    end
    idle();
    cp0_entryhi = 32'h0040_2005; #1;
    total++; if (index_write_index !== 4'd3 || index_write_p !== 1'b0) begin
      bad++; $display("FAIL multi_probe got=%0h/%0h exp=3/0", index_write_index, index_write_p);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    write_wi(32'd7, 32'h0080_0005, 32'h0000_2016, 32'h0000_2056);
    s0_req = 1'b1; s0_vaddr = 32'h0080_0000; s0_asid = 8'h05;
    tick();
    total++; if (s0_found !== 1'b0) begin bad++; $display("FAIL same_cycle_old got=%0h exp=0", s0_found); end
    is_TLBWI = 1'b0;
    tick();
    total++; if (s0_found !== 1'b1 || s0_index !== 4'd7 || s0_pfn !== 20'h00080) begin
      bad++; $display("FAIL next_cycle_new got=%0h/%0h/%0h exp=1/7/80", s0_found, s0_index, s0_pfn);
    end
    idle();
  endtask

  task automatic test_wi_precedence();
    write_wi(32'd12, 32'h0100_0005, 32'h0000_3016, 32'h0000_3056);
    is_TLBWR = 1'b1;
    tick();
    idle();
    cp0_index = 32'd12; #1;
    total++; if (TLB_rdata[77:59] !== 19'h00800 || TLB_rdata[49:30] !== 20'h000c0) begin
      bad++; $display("FAIL wi_precedence got=%0h/%0h exp=800/c0", TLB_rdata[77:59], TLB_rdata[49:30]);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    s0_vaddr = '0; s0_asid = '0; s1_vaddr = '0; s1_asid = '0;
    cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_random();
    test_lookup();
    test_asid_global();
    test_probe_read();
    test_multi_match();
    test_back_to_back();
    test_wi_precedence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlb_unit.md
TLB_UNIT -- requirements
Module: tlb_unit

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, meaning the number of entries; the index width is 4 bits.
REQ-002 SHALL have ports clk, input, 1, the single clock, and reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports s0_req input 1, s0_vaddr input 32, s0_asid input 8: fetch lookup request.
REQ-004 SHALL have ports s0_found output 1, s0_index output 4, s0_pfn output 20, s0_c output 3, s0_d output 1, s0_v output 1: fetch lookup result.
REQ-005 SHALL have ports s1_req, s1_vaddr, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, with the same widths and meanings as the s0 ports, for the data port.
REQ-006 SHALL have ports is_TLBWI input 1 and is_TLBWR input 1: write requests.
REQ-007 SHALL have ports cp0_index input 32, cp0_entryhi input 32, cp0_entrylo0 input 32, cp0_entrylo1 input 32: the CP0 register image.
REQ-008 SHALL have ports is_TLBR input 1 and TLB_rdata output 78: read.
REQ-009 SHALL have ports is_TLBP input 1, index_write_p output 1, index_write_index output 4: probe.
REQ-010 SHALL have port tlb_random output 4, the current replacement index.

Function
REQ-011 SHALL hold per entry: VPN2[18:0], ASID[7:0], G, PFN0/C0/D0/V0, PFN1/C1/D1/V1.
REQ-012 Entry match SHALL be (VPN2 == vaddr[31:13]) && (G || ASID == asid).
REQ-013 Within a matching entry, the odd page SHALL be selected by vaddr[12]: 0 selects the page-0 fields, 1 selects the page-1 fields.
REQ-014 Lookup ports SHALL be pipelined with 1-cycle latency: a request in cycle N produces results registered and valid in cycle N+1.
REQ-015 When sN_req=0, the sN outputs SHALL hold their previous values.
REQ-016 When there is no match, found SHALL be 0, index SHALL be 0, and pfn/c/d/v SHALL be 0.
REQ-017 When multiple entries match, the lowest index SHALL win, on all ports and for probe.
REQ-018 TLBWI SHALL write entry cp0_index[3:0] at the clock edge.
REQ-019 TLBWR SHALL write entry tlb_random at the clock edge.
REQ-020 Write field mapping SHALL be:
- VPN2 = entryhi[31:13], ASID = entryhi[7:0];
- G = entrylo0[0] & entrylo1[0];
- PFN = lo[25:6], C = lo[5:3], D = lo[2], V = lo[1].
REQ-021 If is_TLBWI and is_TLBWR are both asserted, TLBWI SHALL take precedence.
REQ-022 A lookup, read or probe in the same cycle as a write SHALL see the pre-write contents; the new contents SHALL be visible from the next cycle.
REQ-023 TLB_rdata SHALL be combinational from entry cp0_index[3:0], laid out as:
- [77:59] VPN2, [58:51] ASID, [50] G;
- [49:30] PFN0, [29:27] C0, [26] D0, [25] V0;
- [24:5] PFN1, [4:2] C1, [1] D1, [0] V1.
REQ-024 Probe SHALL be combinational: it matches cp0_entryhi VPN2/ASID; index_write_p = ~hit; index_write_index = the hit index, or 0 on a miss.
REQ-025 TLB_rdata, index_write_p and index_write_index SHALL be valid in the same cycle as is_TLBR/is_TLBP, so that CP0 latches them at that edge.
REQ-026 tlb_random SHALL decrement by 1 every cycle and wrap from 0 to TLBNUM-1.
REQ-027 tlb_random SHALL also decrement in the cycle of a TLBWR; the value written SHALL be the pre-decrement value.

Reset
REQ-028 On reset, all V0/V1 bits SHALL be cleared, so no entry hits after reset.
REQ-029 On reset, the s0/s1 registered outputs SHALL be 0 and tlb_random SHALL be TLBNUM-1.
REQ-030 Reset SHALL override any write or lookup in the same cycle; a lookup requested in the reset cycle SHALL return found=0.
REQ-031 VPN2/ASID/PFN/C/D/G storage SHALL NOT require reset.

Structure
REQ-032 The shared package SHALL hold TLBNUM, the TLB_rdata bit-position constants and the entryhi/entrylo field positions, so that CP0 and tlb_unit use one definition.
REQ-033 The match logic SHALL be one sub-module, tlb_match, instantiated three times (s0, s1, probe); it is combinational and returns hit plus lowest index.

Verification
REQ-034 Reset, then s0_req with vaddr=0x0000_2000 -> next cycle s0_found=0, s0_v=0, s0_pfn=0.
REQ-035 Apply TLBWI with index=3, entryhi=0x0040_2005, lo0=0x0000_1016, lo1=0x0000_1056; next cycle, s1_req with vaddr=0x0040_3000 and asid=0x05 -> following cycle s1_found=1, s1_index=3, s1_pfn=0x00041, s1_c=2, s1_d=1, s1_v=1.
REQ-036 With the REQ-035 entry, a lookup with asid=0x06 -> found=0; rewrite the entry with G set in both lo0 and lo1 -> a lookup with asid=0x06 gives found=1.
REQ-037 Probe with entryhi=0x0040_2005 -> index_write_p=0, index_write_index=3; probe with entryhi=0x1234_6005 -> index_write_p=1, index_write_index=0.
REQ-038 TLBR with index=3 -> TLB_rdata[77:59]=0x00201, [58:51]=0x05, [49:30]=0x00040, [24:5]=0x00041.
REQ-039 Write and s0 lookup to the same VPN2 in the same cycle -> result reflects old contents; repeat next cycle -> new contents.
REQ-040 Ten cycles after reset, tlb_random=5; a TLBWR in that cycle writes entry 5, and tlb_random reads 4 in the next cycle.
